cam_capture_ctrl: RTL and testbench

- Parametrised successor to the OV7670 pixel-capture path.
- Samples the camera DVP bus (vsync, href, 8-bit data) on the pixel clock and assembles pixels in RGB565 or Y-only (luma-only) mode.
- Produces linear frame-buffer write strobes, addresses and data for the dual-port frame RAM read by the Wishbone side.
- Adds arm/single-shot control, line-length checking, a frame counter, and proper line-based addressing.

---
 rtl/cam_capture_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// Purpose : DVP camera capture; assembles RGB565 or Y-only pixels into linear frame-RAM writes.
// Latency : we/addr/wdata are valid 2 pclk after the byte that completes a pixel is sampled.
// Backpr. : none; the camera cannot be stalled, and the frame RAM accepts one write per pclk.
//
// Ports   : pclk/reset (sync, active-high); arm, continuous, mode control inputs;
//           vsync/href/data camera bus; we/addr/wdata frame-RAM write port;
//           busy, frame_done, line_err (sticky), frame_cnt status outputs.
// Option  : define CAM_DECIM2_EN to add the 'decim' input (2x2 decimated capture).
module cam_capture_ctrl #(
   parameter int H_PIX   = 320,
   parameter int V_LINES = 240,
   parameter int ADDR_W  = 17,
   parameter int DATA_W  = 16
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              arm,
   input  logic              continuous,
   input  logic              mode,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        data,
`ifdef CAM_DECIM2_EN
   input  logic              decim,
`endif
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              frame_done,
   output logic              line_err,
   output logic [7:0]        frame_cnt
);

   localparam int COL_W = $clog2(H_PIX + 1);
   localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_VS, S_WAIT_LINE, S_LINE, S_LINE_END, S_FRAME_END
   } state_t;

   // Two-deep input pipeline: the first stage is the registered copy used for
   // edge detection, the second stage is what the FSM consumes. This lets the
   // FSM enter LINE on the href rising edge without losing the first byte.
   logic        vsync_q, vsync_qq, href_q, href_qq, arm_q;
   logic [7:0]  data_q, data_qq;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   line_base_q, line_base_d;
   logic                phase_q, phase_d;
   logic [7:0]          hi_q, hi_d;
   logic                overrun_q, overrun_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                line_err_q, line_err_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;
`ifdef CAM_DECIM2_EN
   logic [ADDR_W-1:0]   dbase_q, dbase_d;
`endif

   logic vs_rise, vs_fall, href_rise, href_fall, arm_rise;
   logic err_set, pix_vld, wr_ok;
   logic [DATA_W-1:0] pix;
   logic [ADDR_W-1:0] wr_addr;

   assign vs_rise   =  vsync_q & ~vsync_qq;
   assign vs_fall   = ~vsync_q &  vsync_qq;
   assign href_rise =  href_q  & ~href_qq;
   assign href_fall = ~href_q  &  href_qq;
   assign arm_rise  =  arm     & ~arm_q;

   // Write enable/address for the pixel at col_q; decimation drops odd rows and
   // columns and packs the survivors densely.
`ifdef CAM_DECIM2_EN
   assign wr_ok   = !(decim && (col_q[0] || row_q[0]));
   assign wr_addr = decim ? (dbase_q + ADDR_W'(col_q >> 1))
                          : (line_base_q + ADDR_W'(col_q));
`else
   assign wr_ok   = 1'b1;
   assign wr_addr = line_base_q + ADDR_W'(col_q);
`endif

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      line_base_d  = line_base_q;
      phase_d      = phase_q;
      hi_d         = hi_q;
      overrun_d    = overrun_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      err_set      = 1'b0;
      pix_vld      = 1'b0;
      pix          = '0;
`ifdef CAM_DECIM2_EN
      dbase_d      = dbase_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (arm) state_d = S_WAIT_VS;
         end

         // Waiting for the end of a sync pulse. Dropping arm before a frame
         // has started cancels the pending capture.
         S_WAIT_VS: begin
            if (!arm) begin
               state_d = S_IDLE;
            end else if (vs_fall) begin
               busy_d      = 1'b1;
               row_d       = '0;
               line_base_d = '0;
`ifdef CAM_DECIM2_EN
               dbase_d     = '0;
`endif
               state_d     = S_WAIT_LINE;
            end
         end

         S_WAIT_LINE: begin
            if (vs_rise) begin
               err_set = 1'b1;
               busy_d  = 1'b0;
               state_d = arm ? S_WAIT_VS : S_IDLE;
            end else if (href_rise) begin
               col_d     = '0;
               phase_d   = 1'b0;
               overrun_d = 1'b0;
               state_d   = S_LINE;
            end
         end

         S_LINE: begin
            if (vs_rise) begin
               err_set = 1'b1;
               busy_d  = 1'b0;
               state_d = arm ? S_WAIT_VS : S_IDLE;
            end else begin
               // The last byte of a line is still in the second stage when the
               // falling edge is seen, so it is consumed in the same cycle.
               if (href_qq) begin
                  phase_d = ~phase_q;
                  if (!phase_q) begin
                     hi_d = data_qq;
                     if (mode) begin
                        pix_vld  = 1'b1;
                        pix[7:0] = data_qq;
                     end
                  end else if (!mode) begin
                     pix_vld   = 1'b1;
                     pix[15:0] = {hi_q, data_qq};
                  end
                  if (pix_vld) begin
                     if (col_q < COL_W'(H_PIX)) begin
                        // col saturates at H_PIX; the overrun flag records
                        // anything beyond it.
                        col_d = col_q + COL_W'(1);
                        if (wr_ok) begin
                           we_d    = 1'b1;
                           addr_d  = wr_addr;
                           wdata_d = pix;
                        end
                     end else begin
                        overrun_d = 1'b1;
                     end
                  end
               end
               if (href_fall) state_d = S_LINE_END;
            end
         end

         S_LINE_END: begin
            if (vs_rise) begin
               err_set = 1'b1;
               busy_d  = 1'b0;
               state_d = arm ? S_WAIT_VS : S_IDLE;
            end else begin
               if (col_q != COL_W'(H_PIX) || overrun_q || phase_q) err_set = 1'b1;
               row_d       = row_q + ROW_W'(1);
               line_base_d = line_base_q + ADDR_W'(H_PIX);
`ifdef CAM_DECIM2_EN
               if (row_q[0]) dbase_d = dbase_q + ADDR_W'(H_PIX / 2);
`endif
               state_d = (row_q == ROW_W'(V_LINES - 1)) ? S_FRAME_END : S_WAIT_LINE;
            end
         end

         S_FRAME_END: begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            busy_d       = 1'b0;
            state_d      = (continuous && arm) ? S_WAIT_VS : S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // A new error outranks a clear arriving in the same cycle.
      line_err_d = err_set | (line_err_q & ~arm_rise);
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         vsync_q      <= 1'b0;
         vsync_qq     <= 1'b0;
         href_q       <= 1'b0;
         href_qq      <= 1'b0;
         data_q       <= '0;
         data_qq      <= '0;
         arm_q        <= 1'b0;
         state_q      <= S_IDLE;
         col_q        <= '0;
         row_q        <= '0;
         line_base_q  <= '0;
         phase_q      <= 1'b0;
         hi_q         <= '0;
         overrun_q    <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         line_err_q   <= 1'b0;
         frame_cnt_q  <= '0;
`ifdef CAM_DECIM2_EN
         dbase_q      <= '0;
`endif
      end else begin
         vsync_q      <= vsync;
         vsync_qq     <= vsync_q;
         href_q       <= href;
         href_qq      <= href_q;
         data_q       <= data;
         data_qq      <= data_q;
         arm_q        <= arm;
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         line_base_q  <= line_base_d;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         overrun_q    <= overrun_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         line_err_q   <= line_err_d;
         frame_cnt_q  <= frame_cnt_d;
`ifdef CAM_DECIM2_EN
         dbase_q      <= dbase_d;
`endif
      end
   end

   assign we         = we_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign line_err   = line_err_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Purpose : bench for cam_capture_ctrl with a small frame (4x2) and random camera data.
// Latency : the model queues expected writes per line; a negedge monitor pops and compares.
// Backpr. : none; the camera stream is driven free-running as a real sensor would.
module tb_cam_capture_ctrl;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int AW = 8;
   localparam int DW = 16;

   logic          pclk = 1'b0;
   logic          reset, arm, continuous, mode, vsync, href;
   logic [7:0]    data;
   logic          we, busy, frame_done, line_err;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [7:0]    frame_cnt;

   always #5 pclk = ~pclk;

   cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
      .pclk(pclk), .reset(reset), .arm(arm), .continuous(continuous), .mode(mode),
      .vsync(vsync), .href(href), .data(data),
      .we(we), .addr(addr), .wdata(wdata), .busy(busy), .frame_done(frame_done),
      .line_err(line_err), .frame_cnt(frame_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   int exp_addr_q[$];
   int exp_data_q[$];
   int exp_cnt   = 0;
   bit exp_err   = 1'b0;
   int exp_done  = 0;
   int done_seen = 0;
   bit mon_en    = 1'b0;
   bit seq_data  = 1'b0;
   int drop_arm_at = -1;
   int line_len[0:7];
   int m_ea, m_ed;

   always @(negedge pclk) begin
      if (mon_en) begin
         if (we) begin
            if (exp_addr_q.size() == 0) begin
               check("unexpected_we", 32'(we), 32'd0);
            end else begin
               m_ea = exp_addr_q.pop_front();
               m_ed = exp_data_q.pop_front();
               check("wr_addr", 32'(addr), m_ea);
               check("wr_data", 32'(wdata), m_ed);
            end
         end
         if (frame_done) done_seen++;
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   // One camera line of n bytes. If captured, row r contributes pixel p at
   // address r*H+p for every complete pixel with p < H.
   task automatic send_line(input int r, input int n, input bit cap, input bit md);
      logic [7:0] b [0:31];
      int npix;
      for (int k = 0; k < n; k++) b[k] = seq_data ? 8'(k + 1) : 8'($urandom);
      if (cap && r < V) begin
         npix = md ? (n + 1) / 2 : n / 2;
         for (int p = 0; p < npix && p < H; p++) begin
            exp_addr_q.push_back(r * H + p);
            exp_data_q.push_back(md ? int'(b[2*p]) : int'({b[2*p], b[2*p+1]}));
         end
         if (n != 2 * H) exp_err = 1'b1;
      end
      href = 1'b1;
      for (int k = 0; k < n; k++) begin
         data = b[k];
         tick();
      end
      href = 1'b0;
      data = 8'($urandom);
      repeat (4) tick();
   endtask

   task automatic send_frame(input int nlines, input bit cap, input bit md);
      mode  = md;
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (3) tick();
      for (int r = 0; r < nlines; r++) begin
         send_line(r, line_len[r], cap, md);
         if (r == drop_arm_at) arm = 1'b0;
      end
      if (cap && nlines >= V) begin
         exp_cnt  = (exp_cnt + 1) % 256;
         exp_done = exp_done + 1;
      end
      repeat (4) tick();
   endtask

   task automatic frame_checks(input string tag);
      check({tag, "_cnt"},     32'(frame_cnt), exp_cnt);
      check({tag, "_err"},     32'(line_err), 32'(exp_err));
      check({tag, "_busy"},    32'(busy), 32'd0);
      check({tag, "_done"},    done_seen, exp_done);
      check({tag, "_pending"}, exp_addr_q.size(), 0);
   endtask

   task automatic rearm_clear();
      arm = 1'b0;
      tick();
      tick();
      arm = 1'b1;
      exp_err = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; arm = 1'b0; continuous = 1'b0; mode = 1'b0;
      vsync = 1'b0; href = 1'b0; data = 8'h00;
      for (int i = 0; i < 8; i++) line_len[i] = 2 * H;
      repeat (3) tick();
      check("rst_we",    32'(we), 0);
      check("rst_addr",  32'(addr), 0);
      check("rst_wdata", 32'(wdata), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_done",  32'(frame_done), 0);
      check("rst_err",   32'(line_err), 0);
      check("rst_cnt",   32'(frame_cnt), 0);
      reset = 1'b0;
      tick();
      mon_en = 1'b1;

      // Directed RGB565 frame, bytes 01..08 per line, single shot.
      arm = 1'b1;
      seq_data = 1'b1;
      send_frame(V, 1'b1, 1'b0);
      seq_data = 1'b0;
      frame_checks("rgb");
      arm = 1'b0;
      tick();
      send_frame(V, 1'b0, 1'b0);
      frame_checks("idle");

      // Y-only frame.
      arm = 1'b1;
      send_frame(V, 1'b1, 1'b1);
      frame_checks("yonly");

      // Short second line, then a clean frame starting again at address 0.
      line_len[1] = 6;
      send_frame(V, 1'b1, 1'b0);
      line_len[1] = 2 * H;
      frame_checks("short");
      send_frame(V, 1'b1, 1'b0);
      frame_checks("after_short");
      rearm_clear();
      check("err_clear", 32'(line_err), 0);

      // Truncated frame: vsync returns after one line.
      send_frame(1, 1'b1, 1'b0);
      check("trunc_busy", 32'(busy), 1);
      exp_err = 1'b1;
      send_frame(V, 1'b1, 1'b0);
      frame_checks("trunc");
      rearm_clear();

      // Continuous capture; an extra line is ignored; arm drops in frame 3.
      continuous = 1'b1;
      send_frame(V, 1'b1, 1'b0);
      frame_checks("cont1");
      send_frame(V + 1, 1'b1, 1'b1);
      frame_checks("cont2");
      drop_arm_at = 0;
      send_frame(V, 1'b1, 1'b0);
      drop_arm_at = -1;
      frame_checks("cont3");
      send_frame(V, 1'b0, 1'b0);
      frame_checks("cont_stop");
      continuous = 1'b0;

      // Reset in the middle of a line, after two pixels have been written.
      mon_en = 1'b0;
      arm = 1'b1;
      mode = 1'b0;
      vsync = 1'b1;
      repeat (3) tick();
      vsync = 1'b0;
      repeat (3) tick();
      href = 1'b1;
      for (int k = 0; k < 6; k++) begin
         data = 8'(k + 1);
         tick();
      end
      reset = 1'b1;
      tick();
      check("mid_rst_we",   32'(we), 0);
      check("mid_rst_addr", 32'(addr), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_cnt",  32'(frame_cnt), 0);
      reset = 1'b0;
      href = 1'b0;
      repeat (3) tick();
      exp_addr_q.delete();
      exp_data_q.delete();
      exp_cnt = 0; exp_err = 1'b0; exp_done = 0; done_seen = 0;
      mon_en = 1'b1;
      send_frame(V, 1'b1, 1'b0);
      frame_checks("post_rst");

      // Randomized continuous frames with occasional bad line lengths.
      continuous = 1'b1;
      for (int f = 0; f < 8; f++) begin
         for (int r = 0; r < V; r++)
            line_len[r] = ($urandom % 4 == 0) ? int'($urandom_range(1, 2 * H + 3)) : 2 * H;
         send_frame(V, 1'b1, 1'($urandom));
         frame_checks("rand");
         if (exp_err) rearm_clear();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
